data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4 (range 1-15): BUSY cycles per access.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 256: backing store size in 32-bit words, a power of two.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MEM_READ  in  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; other codes = none.
- MEM_WRITE  in  3  000 none, 001 SB, 010 SH, 011 SW; other codes = none.
- ADDRESS  in  32  byte address.
- WRITE_DATA  in  32  store data, right-aligned.
- READ_DATA  out  32  load result, extended to 32 bits.
- BUSY_WAIT  out  1  stall request to all pipeline registers.
- MISALIGNED  out  1  one-cycle error pulse.

Function
REQ-004 The FSM SHALL have three states, IDLE, BUSY and DONE, with these transitions:
- IDLE -> BUSY on a valid request.
- BUSY -> DONE when the counter is 0.
- DONE -> IDLE unconditionally.
REQ-005 A request SHALL be valid when MEM_READ or MEM_WRITE holds a defined non-zero code.
REQ-006 In IDLE, BUSY_WAIT SHALL be combinationally high in the same cycle a valid request is present, so the pipeline stalls at the next edge.
REQ-007 On the IDLE->BUSY edge, the block SHALL:
- capture opcode, ADDRESS and WRITE_DATA;
- ignore later input changes until IDLE is re-entered;
- load the counter with LATENCY-1.
REQ-008 In BUSY, BUSY_WAIT SHALL be high, and the counter SHALL decrement by 1 per edge.
REQ-009 On the BUSY->DONE edge, the block SHALL perform the access and register READ_DATA.
REQ-010 In DONE, BUSY_WAIT SHALL be low, and the still-present request SHALL be ignored (no retrigger); the pipeline advances at the edge ending DONE.
REQ-011 BUSY_WAIT SHALL be high for exactly LATENCY+1 consecutive cycles per access.
REQ-012 Loads SHALL extend as follows:
- LB and LH sign-extend.
- LBU and LHU zero-extend.
- LW returns the word.
REQ-013 Byte lane selection SHALL use ADDRESS[1:0] (little-endian).
REQ-014 Stores SHALL be byte-masked: SB writes lane ADDRESS[1:0], SH writes lanes {A1,0}/{A1,1}, SW writes all lanes.
REQ-015 READ_DATA SHALL be unchanged by stores.
REQ-016 The word index SHALL be ADDRESS[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-017 If MEM_READ and MEM_WRITE are both valid, the write SHALL be performed and the read ignored.
REQ-018 Misalignment SHALL be defined as halfword access with ADDRESS[0]=1, or word access with ADDRESS[1:0]!=0.
REQ-019 On a misaligned access, the block SHALL:
- keep the full LATENCY timing;
- leave memory unmodified;
- drive READ_DATA=0 in DONE;
- pulse MISALIGNED high during the DONE cycle only.
REQ-020 READ_DATA SHALL hold its value until the next load completes.

Reset
REQ-021 While RESET=0, the block SHALL:
- force the FSM to IDLE and the counter to 0;
- drive READ_DATA=0, BUSY_WAIT=0 and MISALIGNED=0, all asynchronously.
REQ-022 Reset asserted mid-access SHALL drop the pending access; a write not yet performed SHALL never occur.
REQ-023 Reset SHALL NOT clear backing-store contents.
REQ-024 After RESET rises, the first rising edge SHALL be able to accept a request.

Structure
REQ-025 Package mem_pkg SHALL hold the MEM_READ/MEM_WRITE opcode constants and the FSM state encoding.
REQ-026 Sub-module mem_lane_align SHALL be combinational and SHALL produce:
- byte-enable mask and shifted store data;
- load lane extract and extension;
- misalignment flag.
REQ-027 The backing store SHALL be a DEPTH_WORDS x 32 register array with per-byte write enable, inside data_mem_responder.

Verification
REQ-028 SW 0xDEADBEEF to 0x10, then LW 0x10 (LATENCY=4) -> BUSY_WAIT high 5 cycles each, READ_DATA=0xDEADBEEF in DONE.
REQ-029 After REQ-028, SB 0x7F to 0x11, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LW 0x10 -> 0xDEAD7FEF.
REQ-030 LH at 0x12 -> 0xFFFFDEAD; LH at 0x11 -> MISALIGNED pulse, READ_DATA=0, memory unchanged.
REQ-031 Request held for 3 cycles after DONE (pipeline still stalled by other logic) -> exactly one access per IDLE acceptance; no spurious BUSY_WAIT in DONE.
REQ-032 SW 0x12345678 to 0x20, RESET low during BUSY cycle 2 -> BUSY_WAIT falls immediately; subsequent LW 0x20 returns the prior contents.
REQ-033 LW at 0x410 with DEPTH_WORDS=256 -> returns word at 0x010 (wrap-around).

Source files
------------

// File: rtl/mem_pkg.sv
// Opcode constants, FSM state encoding and opcode helpers for the data memory responder.
package mem_pkg;

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LH   = 3'b010;
  localparam logic [2:0] RD_LW   = 3'b011;
  localparam logic [2:0] RD_LBU  = 3'b100;
  localparam logic [2:0] RD_LHU  = 3'b101;

  localparam logic [2:0] WR_NONE = 3'b000;
  localparam logic [2:0] WR_SB   = 3'b001;
  localparam logic [2:0] WR_SH   = 3'b010;
  localparam logic [2:0] WR_SW   = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_t;

  function automatic logic rd_valid(input logic [2:0] op);
    return (op >= RD_LB) && (op <= RD_LHU);
  endfunction

  function automatic logic wr_valid(input logic [2:0] op);
    return (op >= WR_SB) && (op <= WR_SW);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Pipeline-side memory port: opcodes, address and data in; load result and stall out.
interface data_mem_responder_if;
  logic [2:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY_WAIT;
  logic        MISALIGNED;

  modport master (
    output MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA,
    input  READ_DATA, BUSY_WAIT, MISALIGNED
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA,
    output READ_DATA, BUSY_WAIT, MISALIGNED
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables/data, load extract/extension, alignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_rd_op,
  input  logic [2:0]  i_wr_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic        w_is_wr;
  size_t       w_size;
  logic [31:0] w_shifted;

  assign w_is_wr   = wr_valid(i_wr_op);
  assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

  // A store takes priority, so its size governs the alignment check.
  always_comb begin
    w_size = SZ_NONE;
    if (w_is_wr) begin
      unique case (i_wr_op)
        WR_SB:   w_size = SZ_BYTE;
        WR_SH:   w_size = SZ_HALF;
        WR_SW:   w_size = SZ_WORD;
        default: w_size = SZ_NONE;
      endcase
    end else begin
      case (i_rd_op)
        RD_LB, RD_LBU: w_size = SZ_BYTE;
        RD_LH, RD_LHU: w_size = SZ_HALF;
        RD_LW:         w_size = SZ_WORD;
        default:       w_size = SZ_NONE;
      endcase
    end
  end

  always_comb begin
    o_misaligned = 1'b0;
    if (w_size == SZ_HALF) o_misaligned = i_addr_lo[0];
    if (w_size == SZ_WORD) o_misaligned = (i_addr_lo != 2'b00);
  end

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    case (i_wr_op)
      WR_SB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      WR_SH: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      WR_SW: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: ;
    endcase
    if (o_misaligned) o_be = 4'b0000;
  end

  always_comb begin
    o_rdata = 32'h0;
    case (i_rd_op)
      RD_LB:   o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      RD_LH:   o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      RD_LW:   o_rdata = w_shifted;
      RD_LBU:  o_rdata = {24'h0, w_shifted[7:0]};
      RD_LHU:  o_rdata = {16'h0, w_shifted[15:0]};
      default: ;
    endcase
    if (o_misaligned) o_rdata = 32'h0;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: accepts one load/store in IDLE, stalls the pipeline for LATENCY+1 cycles.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 256
)(
  input  logic CLK,
  input  logic RESET,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic [2:0]    r_rd_op, r_wr_op;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_mis;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req, w_accept, w_fire;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_sh, w_rdata_ext, w_rword;
  logic          w_mis;

  assign w_req    = rd_valid(bus.MEM_READ) || wr_valid(bus.MEM_WRITE);
  assign w_accept = (r_state == ST_IDLE) && w_req;
  assign w_fire   = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_idx    = r_addr[AW+1:2];
  assign w_rword  = r_mem[w_idx];

  mem_lane_align u_align (
    .i_rd_op      (r_rd_op),
    .i_wr_op      (r_wr_op),
    .i_addr_lo    (r_addr[1:0]),
    .i_wdata      (r_wdata),
    .i_rword      (w_rword),
    .o_be         (w_be),
    .o_wdata      (w_wdata_sh),
    .o_rdata      (w_rdata_ext),
    .o_misaligned (w_mis)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_next = ST_BUSY;
      ST_BUSY: if (r_cnt == 4'd0) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt   <= 4'd0;
      r_rd_op <= RD_NONE;
      r_wr_op <= WR_NONE;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_mis   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(LATENCY - 1);
        r_rd_op <= bus.MEM_READ;
        r_wr_op <= bus.MEM_WRITE;
        r_addr  <= bus.ADDRESS[AW+1:0];
        r_wdata <= bus.WRITE_DATA;
      end else if (r_state == ST_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Loads shadowed by a simultaneous store leave READ_DATA alone.
      if (w_fire) begin
        r_mis <= w_mis;
        if (w_mis)
          r_rdata <= 32'h0;
        else if (!wr_valid(r_wr_op) && rd_valid(r_rd_op))
          r_rdata <= w_rdata_ext;
      end
    end
  end

  // No reset on the array: contents survive RESET, and w_fire is already gated by the FSM.
  always_ff @(posedge CLK) begin
    if (w_fire && wr_valid(r_wr_op)) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
    end
  end

  assign bus.BUSY_WAIT  = RESET && (w_accept || (r_state == ST_BUSY));
  assign bus.MISALIGNED = (r_state == ST_DONE) && r_mis;
  assign bus.READ_DATA  = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with hand-computed expected values, LATENCY=4.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  int   n_chk  = 0;
  int   n_pass = 0;

  data_mem_responder_if bus ();

  data_mem_responder #(.LATENCY(4), .DEPTH_WORDS(256)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  // Drives one request at a negedge, counts stalled cycles, samples outputs in DONE, then drops it.
  task automatic access(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic mis,
                        output int busy);
    @(negedge CLK);
    bus.MEM_READ = rd; bus.MEM_WRITE = wr; bus.ADDRESS = addr; bus.WRITE_DATA = wd;
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.BUSY_WAIT) busy++;
      else break;
      @(negedge CLK);
    end
    rdata = bus.READ_DATA;
    mis   = bus.MISALIGNED;
    bus.MEM_READ = RD_NONE; bus.MEM_WRITE = WR_NONE;
  endtask

  logic [31:0] rd;
  logic        mis;
  int          busy;
  logic [11:0] pat;

  initial begin
    RESET = 1'b0;
    bus.MEM_READ = RD_LW; bus.MEM_WRITE = WR_NONE;
    bus.ADDRESS = 32'h10; bus.WRITE_DATA = 32'h0;
    #22;
    chk("rst_busy", {31'h0, bus.BUSY_WAIT}, 32'h0);
    chk("rst_rdata", bus.READ_DATA, 32'h0);
    chk("rst_mis", {31'h0, bus.MISALIGNED}, 32'h0);
    bus.MEM_READ = RD_NONE;
    @(negedge CLK); RESET = 1'b1;

    access(RD_NONE, WR_SW, 32'h10, 32'hDEADBEEF, rd, mis, busy);
    chk("sw_busy", busy, 5);
    chk("sw_mis", {31'h0, mis}, 32'h0);
    access(RD_LW, WR_NONE, 32'h10, 32'h0, rd, mis, busy);
    chk("lw_busy", busy, 5);
    chk("lw_data", rd, 32'hDEADBEEF);

    access(RD_NONE, WR_SB, 32'h11, 32'h0000007F, rd, mis, busy);
    chk("sb_keeps_rdata", rd, 32'hDEADBEEF);
    access(RD_LB, WR_NONE, 32'h13, 32'h0, rd, mis, busy);
    chk("lb_13", rd, 32'hFFFFFFDE);
    access(RD_LBU, WR_NONE, 32'h13, 32'h0, rd, mis, busy);
    chk("lbu_13", rd, 32'h000000DE);
    access(RD_LW, WR_NONE, 32'h10, 32'h0, rd, mis, busy);
    chk("lw_after_sb", rd, 32'hDEAD7FEF);
    access(RD_LH, WR_NONE, 32'h12, 32'h0, rd, mis, busy);
    chk("lh_12", rd, 32'hFFFFDEAD);
    access(RD_LHU, WR_NONE, 32'h12, 32'h0, rd, mis, busy);
    chk("lhu_12", rd, 32'h0000DEAD);
    access(RD_LH, WR_NONE, 32'h10, 32'h0, rd, mis, busy);
    chk("lh_10", rd, 32'h00007FEF);

    access(RD_LH, WR_NONE, 32'h11, 32'h0, rd, mis, busy);
    chk("lh_mis_busy", busy, 5);
    chk("lh_mis_flag", {31'h0, mis}, 32'h1);
    chk("lh_mis_data", rd, 32'h0);
    @(negedge CLK); #1;
    chk("mis_one_cycle", {31'h0, bus.MISALIGNED}, 32'h0);
    access(RD_NONE, WR_SW, 32'h12, 32'h11111111, rd, mis, busy);
    chk("sw_mis_flag", {31'h0, mis}, 32'h1);
    access(RD_LW, WR_NONE, 32'h10, 32'h0, rd, mis, busy);
    chk("mem_unchanged", rd, 32'hDEAD7FEF);

    // Store wins over a simultaneous load; READ_DATA stays at the last load result.
    access(RD_LW, WR_SW, 32'h14, 32'hCAFEF00D, rd, mis, busy);
    chk("rw_keeps_rdata", rd, 32'hDEAD7FEF);
    access(RD_NONE, WR_SH, 32'h16, 32'h0000BEEF, rd, mis, busy);
    access(RD_LW, WR_NONE, 32'h14, 32'h0, rd, mis, busy);
    chk("sh_merge", rd, 32'hBEEFF00D);

    access(3'b110, 3'b111, 32'h10, 32'h0, rd, mis, busy);
    chk("bad_codes_idle", busy, 0);

    // Held request: 5 stall cycles, DONE low, then a fresh acceptance.
    @(negedge CLK);
    bus.MEM_READ = RD_LW; bus.ADDRESS = 32'h10;
    pat = '0;
    for (int i = 11; i >= 0; i--) begin
      #1; pat[i] = bus.BUSY_WAIT;
      if (i != 0) @(negedge CLK);
    end
    bus.MEM_READ = RD_NONE;
    chk("held_pattern", {20'h0, pat}, 32'h00000FBE);
    chk("held_data", bus.READ_DATA, 32'hDEAD7FEF);

    // Reset during BUSY drops the pending store.
    access(RD_NONE, WR_SW, 32'h20, 32'h0BADF00D, rd, mis, busy);
    @(negedge CLK);
    bus.MEM_WRITE = WR_SW; bus.ADDRESS = 32'h20; bus.WRITE_DATA = 32'h12345678;
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_mid_busy", {31'h0, bus.BUSY_WAIT}, 32'h0);
    chk("rst_mid_rdata", bus.READ_DATA, 32'h0);
    bus.MEM_WRITE = WR_NONE;
    @(negedge CLK); RESET = 1'b1;
    access(RD_LW, WR_NONE, 32'h20, 32'h0, rd, mis, busy);
    chk("rst_no_write", rd, 32'h0BADF00D);
    chk("post_rst_busy", busy, 5);

    access(RD_LW, WR_NONE, 32'h410, 32'h0, rd, mis, busy);
    chk("wrap_410", rd, 32'hDEAD7FEF);
    access(RD_NONE, WR_SW, 32'hFFFF0414, 32'hA5A5A5A5, rd, mis, busy);
    access(RD_LW, WR_NONE, 32'h14, 32'h0, rd, mis, busy);
    chk("wrap_store", rd, 32'hA5A5A5A5);

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
